// File: rtl/somador_completo_pkg.sv
// Shared constants and helpers for the registered ripple-carry adder.
// Imported by the top level.
package somador_completo_pkg;

    localparam int DEF_WIDTH = 1;

    // Signed overflow from the carries into and out of the MSB.
    function automatic logic ovf_of(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage

// File: rtl/somador_completo_bit.sv
// Combinational 1-bit full-adder cell.
// Chained by the top level to form the ripple-carry adder.
module somador_completo_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/somador_completo.sv
// Registered full adder: {cout, s} = a + b + cin with signed overflow.
// Ripple chain of 1-bit cells; results captured on the rising clock edge.
module somador_completo
    import somador_completo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        somador_completo_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (sum[i]),
            .cout(c[i+1])
        );
    end

    // Load the fresh sum when enabled, otherwise hold the registered result.
    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (en) begin
            s_d    = sum;
            cout_d = c[WIDTH];
            ovf_d  = ovf_of(c[WIDTH-1], c[WIDTH]);
        end
    end

    // Output registers with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_somador_completo.sv
// Self-checking bench for somador_completo at WIDTH=1 and WIDTH=4.
// Directed table plus a random stream against an arithmetic model.
module tb_somador_completo;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;

    logic [3:0] s4;
    logic       c4, v4;
    logic [0:0] s1;
    logic       c1, v1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    somador_completo #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
        .b   (b),
        .cin (cin),
        .s   (s4),
        .cout(c4),
        .ovf (v4)
    );

    somador_completo #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a[0:0]),
        .b   (b[0:0]),
        .cin (cin),
        .s   (s1),
        .cout(c1),
        .ovf (v1)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [5:0] exp4; // {ovf, cout, s[3:0]}
        logic [2:0] exp1; // {ovf, cout, s}
    } vec_t;

    // Arithmetic reference: {ovf, cout, s} packed as {v, c, s[3:0]}.
    function automatic logic [5:0] model(input int w, input int av,
                                         input int bv, input int ci);
        int u, sa, sb, t, lim;
        logic [5:0] r;
        u   = av + bv + ci;
        lim = 1 << (w - 1);
        sa  = (av >= lim) ? av - (1 << w) : av;
        sb  = (bv >= lim) ? bv - (1 << w) : bv;
        t   = sa + sb + ci;
        r        = '0;
        r[3:0]   = 4'(u % (1 << w));
        r[4]     = 1'((u >> w) & 1);
        r[5]     = (t > lim - 1) || (t < -lim);
        return r;
    endfunction

    task automatic check(input string name, input logic [5:0] got,
                         input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] got4();
        return {v4, c4, s4};
    endfunction

    function automatic logic [5:0] got1();
        return {3'b000, v1, c1, s1};
    endfunction

    vec_t tbl[$];

    initial begin
        logic [5:0] m4, m1;
        logic [5:0] e4, e1;

        // rst, en, a, b, cin, exp4, exp1
        tbl.push_back('{1, 1, 4'h1, 4'h1, 1, 6'b00_0000, 3'b000});
        tbl.push_back('{1, 1, 4'h1, 4'h1, 1, 6'b00_0000, 3'b000});
        tbl.push_back('{0, 1, 4'h0, 4'h0, 0, 6'b00_0000, 3'b000});
        tbl.push_back('{0, 1, 4'h0, 4'h0, 1, 6'b00_0001, 3'b101});
        tbl.push_back('{0, 1, 4'h0, 4'h1, 0, 6'b00_0001, 3'b001});
        tbl.push_back('{0, 1, 4'h0, 4'h1, 1, 6'b00_0010, 3'b010});
        tbl.push_back('{0, 1, 4'h1, 4'h0, 0, 6'b00_0001, 3'b001});
        tbl.push_back('{0, 1, 4'h1, 4'h0, 1, 6'b00_0010, 3'b010});
        tbl.push_back('{0, 1, 4'h1, 4'h1, 0, 6'b00_0010, 3'b110});
        tbl.push_back('{0, 1, 4'h1, 4'h1, 1, 6'b00_0011, 3'b011});
        // hold: capture 1+1+0, then en=0 with changed inputs
        tbl.push_back('{0, 1, 4'h1, 4'h1, 0, 6'b00_0010, 3'b110});
        tbl.push_back('{0, 0, 4'h0, 4'h0, 1, 6'b00_0010, 3'b110});
        tbl.push_back('{0, 0, 4'h0, 4'h0, 1, 6'b00_0010, 3'b110});
        tbl.push_back('{0, 0, 4'h0, 4'h0, 1, 6'b00_0010, 3'b110});
        // wrap
        tbl.push_back('{0, 1, 4'hF, 4'h0, 1, 6'b01_0000, 3'b010});
        tbl.push_back('{0, 1, 4'hF, 4'hF, 1, 6'b01_1111, 3'b011});
        // overflow
        tbl.push_back('{0, 1, 4'h7, 4'h1, 0, 6'b10_1000, 3'b110});
        tbl.push_back('{0, 1, 4'h8, 4'h8, 0, 6'b11_0000, 3'b000});
        // reset overrides a held value with en=0
        tbl.push_back('{1, 0, 4'hF, 4'hF, 1, 6'b00_0000, 3'b000});

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            a   = tbl[i].a;
            b   = tbl[i].b;
            cin = tbl[i].cin;
            step();
            check($sformatf("vec%0d_w4", i), got4(), tbl[i].exp4);
            check($sformatf("vec%0d_w1", i), got1(), {3'b000, tbl[i].exp1});
        end

        // Random stream with a mid-stream reset pulse.
        e4 = '0;
        e1 = '0;
        for (int i = 0; i < 80; i++) begin
            rst = (i == 40);
            en  = (i == 41) ? 1'b1 : ($urandom_range(0, 3) != 0);
            a   = 4'($urandom);
            b   = 4'($urandom);
            cin = 1'($urandom);
            m4 = model(4, int'(a), int'(b), int'(cin));
            m1 = model(1, int'(a[0]), int'(b[0]), int'(cin));
            step();
            if (rst) begin
                e4 = '0;
                e1 = '0;
            end else if (en) begin
                e4 = m4;
                e1 = {3'b000, m1[5:4], m1[0]};
            end
            check($sformatf("rnd%0d_w4", i), got4(), e4);
            check($sformatf("rnd%0d_w1", i), got1(), e1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
